// File: rtl/mem_ctrl_if.sv
// Request/RAM bus of the memory access controller.
// master = control unit plus RAM side, slave = mem_ctrl.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  I_execute;
  logic                  I_we;
  logic [ADDR_WIDTH-1:0] I_addr;
  logic [DATA_WIDTH-1:0] I_data;
  logic                  O_ready;
  logic                  O_data_ready;
  logic [DATA_WIDTH-1:0] O_data;
  logic                  O_overrun;
  logic                  O_ram_en;
  logic                  O_ram_we;
  logic [ADDR_WIDTH-1:0] O_ram_addr;
  logic [DATA_WIDTH-1:0] O_ram_wdata;
  logic [DATA_WIDTH-1:0] I_ram_rdata;

  modport master (
    output I_execute, I_we, I_addr, I_data, I_ram_rdata,
    input  O_ready, O_data_ready, O_data, O_overrun,
           O_ram_en, O_ram_we, O_ram_addr, O_ram_wdata
  );

  modport slave (
    input  I_execute, I_we, I_addr, I_data, I_ram_rdata,
    output O_ready, O_data_ready, O_data, O_overrun,
           O_ram_en, O_ram_we, O_ram_addr, O_ram_wdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory access controller: edge-triggered requests from the control unit,
// one-cycle RAM strobe, WAIT_STATES extra cycles, ready/data-ready handshake.
module mem_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic       I_clk,
  input  logic       I_reset,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT
  } state_t;

  state_t                state, state_nx;
  logic                  execute_q;
  logic                  req;
  logic                  done;
  logic                  op_we;
  logic [3:0]            counter;
  logic                  ram_en_q;
  logic                  ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  data_ready_q;
  logic                  overrun_q;

  assign req  = bus.I_execute & ~execute_q;
  assign done = (state == S_WAIT) && (counter == '0);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (req) state_nx = S_ACCESS;
      S_ACCESS: state_nx = S_WAIT;
      S_WAIT:   if (counter == '0) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset) begin
    if (!I_reset) state <= S_IDLE;
    else          state <= state_nx;
  end

  // ram_we is kept separately in op_we because the strobe drops after
  // the access cycle, but completion still needs to know read vs write.
  always_ff @(posedge I_clk or negedge I_reset) begin
    if (!I_reset) begin
      execute_q    <= 1'b0;
      op_we        <= 1'b0;
      counter      <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      data_q       <= '0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      execute_q    <= bus.I_execute;
      data_ready_q <= 1'b0;
      if (req && (state != S_IDLE)) overrun_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (req) begin
            op_we       <= bus.I_we;
            ram_en_q    <= 1'b1;
            ram_we_q    <= bus.I_we;
            ram_addr_q  <= bus.I_addr;
            ram_wdata_q <= bus.I_data;
            counter     <= 4'(WAIT_STATES);
          end
        end
        S_ACCESS: begin
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
        end
        S_WAIT: begin
          if (counter != '0) begin
            counter <= counter - 4'd1;
          end else if (!op_we) begin
            data_q       <= bus.I_ram_rdata;
            data_ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.O_ready      = (state == S_IDLE);
  assign bus.O_data_ready = data_ready_q;
  assign bus.O_data       = data_q;
  assign bus.O_overrun    = overrun_q;
  assign bus.O_ram_en     = ram_en_q;
  assign bus.O_ram_we     = ram_we_q;
  assign bus.O_ram_addr   = ram_addr_q;
  assign bus.O_ram_wdata  = ram_wdata_q;

  // done is only used to keep the completion condition readable in waves
  logic unused_done;
  assign unused_done = done;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (WAIT_STATES 0 and 3) driven in lockstep,
// each checked every cycle against a latency-countdown transaction model.
module tb_mem_ctrl;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          exec_in = 1'b0;
  logic          we_in = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] data_in = '0;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0)) dut0 (
    .I_clk(clk), .I_reset(rst), .bus(bus0));
  mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(3)) dut1 (
    .I_clk(clk), .I_reset(rst), .bus(bus1));

  assign bus0.I_execute = exec_in;
  assign bus0.I_we      = we_in;
  assign bus0.I_addr    = addr_in;
  assign bus0.I_data    = data_in;
  assign bus1.I_execute = exec_in;
  assign bus1.I_we      = we_in;
  assign bus1.I_addr    = addr_in;
  assign bus1.I_data    = data_in;

  // Synchronous single-port RAMs (contents survive controller reset)
  logic [DW-1:0] ram0 [256];
  logic [DW-1:0] ram1 [256];
  logic [DW-1:0] rdata0 = '0;
  logic [DW-1:0] rdata1 = '0;
  assign bus0.I_ram_rdata = rdata0;
  assign bus1.I_ram_rdata = rdata1;

  always @(posedge clk) begin
    if (bus0.O_ram_en) begin
      if (bus0.O_ram_we) ram0[bus0.O_ram_addr[7:0]] <= bus0.O_ram_wdata;
      else               rdata0 <= ram0[bus0.O_ram_addr[7:0]];
    end
    if (bus1.O_ram_en) begin
      if (bus1.O_ram_we) ram1[bus1.O_ram_addr[7:0]] <= bus1.O_ram_wdata;
      else               rdata1 <= ram1[bus1.O_ram_addr[7:0]];
    end
  end

  // Reference model: an accepted request completes exactly 2+WS edges later
  int            ws [2] = '{0, 3};
  logic [DW-1:0] shadow [2][256];
  bit            busy [2];
  int            remain [2];
  bit            m_we [2];
  bit            m_en [2];
  bit            m_dr [2];
  bit            m_ovr [2];
  bit            pend_wr [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2];
  logic [DW-1:0] m_data [2];
  bit            exec_prev;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      busy[d] = 0; remain[d] = 0; m_we[d] = 0; m_en[d] = 0; m_dr[d] = 0;
      m_ovr[d] = 0; pend_wr[d] = 0; m_addr[d] = '0; m_wdata[d] = '0;
      m_data[d] = '0;
    end
    exec_prev = 0;
  endtask

  task automatic model_step();
    bit req;
    req = exec_in & ~exec_prev;
    exec_prev = exec_in;
    for (int d = 0; d < 2; d++) begin
      m_en[d] = 0;
      m_dr[d] = 0;
      if (pend_wr[d]) begin
        shadow[d][m_addr[d][7:0]] = m_wdata[d];
        pend_wr[d] = 0;
      end
      if (busy[d]) begin
        if (req) m_ovr[d] = 1;
        remain[d]--;
        if (remain[d] == 0) begin
          busy[d] = 0;
          if (!m_we[d]) begin
            m_data[d] = shadow[d][m_addr[d][7:0]];
            m_dr[d]   = 1;
          end
        end
      end else if (req) begin
        busy[d]    = 1;
        remain[d]  = 2 + ws[d];
        m_en[d]    = 1;
        m_we[d]    = we_in;
        m_addr[d]  = addr_in;
        m_wdata[d] = data_in;
        pend_wr[d] = we_in;
      end
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s[ws=%0d] t=%0t: observed %0h expected %0h",
             tag, ws[d], $time, obs, exp);
    end
  endtask

  task automatic chk_dut(input int d, input logic rdy, input logic dr,
                         input logic [DW-1:0] data, input logic ovr,
                         input logic en, input logic rwe,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    chk("ready",      d, 32'(rdy),   32'(!busy[d]));
    chk("data_ready", d, 32'(dr),    32'(m_dr[d]));
    chk("data",       d, 32'(data),  32'(m_data[d]));
    chk("overrun",    d, 32'(ovr),   32'(m_ovr[d]));
    chk("ram_en",     d, 32'(en),    32'(m_en[d]));
    chk("ram_we",     d, 32'(rwe),   32'(m_en[d] & m_we[d]));
    chk("ram_addr",   d, 32'(addr),  32'(m_addr[d]));
    chk("ram_wdata",  d, 32'(wdata), 32'(m_wdata[d]));
  endtask

  task automatic check_all();
    chk_dut(0, bus0.O_ready, bus0.O_data_ready, bus0.O_data, bus0.O_overrun,
            bus0.O_ram_en, bus0.O_ram_we, bus0.O_ram_addr, bus0.O_ram_wdata);
    chk_dut(1, bus1.O_ready, bus1.O_data_ready, bus1.O_data, bus1.O_overrun,
            bus1.O_ram_en, bus1.O_ram_we, bus1.O_ram_addr, bus1.O_ram_wdata);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_step();
    #1;
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Called at posedge+1; pulses reset low mid-cycle, across one edge
  task automatic async_reset();
    #2;
    rst = 1'b0;
    exec_in = 1'b0;
    #1;
    model_reset();
    check_all();
    cycle();
    #2;
    rst = 1'b1;
  endtask

  task automatic request(input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] dat, input int hold);
    exec_in = 1'b1; we_in = we; addr_in = a; data_in = dat;
    cycles(hold);
    exec_in = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram0[i] = 16'(i * 16'h0101 + 16'h5a00);
      ram1[i] = ram0[i];
      shadow[0][i] = ram0[i];
      shadow[1][i] = ram0[i];
    end
    ram0[8'h10] = 16'hBEEF; ram1[8'h10] = 16'hBEEF;
    shadow[0][8'h10] = 16'hBEEF; shadow[1][8'h10] = 16'hBEEF;
    model_reset();

    // Reset state, then release mid-cycle
    #1;
    check_all();
    cycles(2);
    #2 rst = 1'b1;
    cycle();

    // Single-cycle read of 0x0010 (RAM holds 0xBEEF)
    request(1'b0, 16'h0010, 16'h0000, 1);
    cycles(8);

    // Write 0x1234 to 0x0020, then read it back
    request(1'b1, 16'h0020, 16'h1234, 1);
    cycles(8);
    request(1'b0, 16'h0020, 16'h0000, 1);
    cycles(8);

    // Level held for 4 cycles is a single request
    request(1'b0, 16'h0011, 16'h0000, 4);
    cycles(6);

    // Second edge while busy: overrun, first access still completes
    request(1'b0, 16'h0012, 16'h0000, 1);
    cycle();
    request(1'b0, 16'h0013, 16'h0000, 1);
    cycles(8);
    async_reset();
    cycle();

    // Back-to-back: next request issued in the first idle cycle of the ws=0 unit
    request(1'b0, 16'h0030, 16'h0000, 1);
    for (int k = 0; k < 6 && busy[0]; k++) cycle();
    request(1'b0, 16'h0031, 16'h0000, 1);
    cycles(8);
    async_reset();
    cycle();

    // Reset in the middle of an access, then a fresh read
    request(1'b0, 16'h0040, 16'h0000, 1);
    cycle();
    async_reset();
    cycle();
    request(1'b0, 16'h0010, 16'h0000, 1);
    cycles(8);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_reset();
      end else begin
        exec_in = ($urandom_range(0, 2) == 0);
        we_in   = 1'($urandom);
        addr_in = 16'($urandom);
        data_in = 16'($urandom);
      end
      cycle();
    end
    exec_in = 1'b0;
    cycles(8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory access controller that sits directly downstream of the control unit, between it and a single-port synchronous RAM.
- Accepts one-cycle execute requests (instruction fetch, READ, WRITE) and drives the RAM strobes with a configurable number of wait states.
- Returns the ready/data-ready handshake the control unit sequences on: O_ready feeds its mem_ready input, O_data_ready feeds its data_ready input, O_data feeds its instruction/data input.

Parameters:
- ADDR_WIDTH, 16, width of request and RAM address.
- DATA_WIDTH, 16, width of write data, read data and RAM data buses.
- WAIT_STATES, 0, extra cycles inserted per access (0..15), loaded into a 4-bit counter.

Ports:
- I_clk  input  1  clock; all state changes on rising edge.
- I_reset  input  1  asynchronous, active-low reset.
- I_execute  input  1  request strobe; acted on at its rising edge only.
- I_we  input  1  1 = write access, 0 = read access; sampled with the request.
- I_addr  input  ADDR_WIDTH  access address; sampled with the request.
- I_data  input  DATA_WIDTH  write data; sampled with the request.
- O_ready  output  1  1 = idle, next request will be accepted.
- O_data_ready  output  1  one-cycle pulse; O_data is valid (reads only).
- O_data  output  DATA_WIDTH  last read data; holds until the next read completes.
- O_overrun  output  1  sticky error: a request edge arrived while busy.
- O_ram_en  output  1  RAM access strobe, exactly one cycle per access.
- O_ram_we  output  1  RAM write enable; only ever high together with O_ram_en.
- O_ram_addr  output  ADDR_WIDTH  RAM address, held for the whole access.
- O_ram_wdata  output  DATA_WIDTH  RAM write data, held for the whole access.
- I_ram_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after O_ram_en is sampled.

Behaviour:
- Reset (I_reset=0, asynchronous, overrides everything):
  - O_ready=1; O_data_ready=0; O_data=0; O_overrun=0.
  - O_ram_en=0; O_ram_we=0; O_ram_addr=0; O_ram_wdata=0.
  - Internal registers: execute_q=0, state=IDLE, counter=0.
  - Reset during an access abandons it; no O_data_ready pulse is generated.
- Request detection: req = I_execute & ~execute_q, with execute_q registered every cycle.
  - A level held high for several cycles is one request.
- States and transitions:
  - IDLE: O_ready=1. On req at edge E0: latch I_we/I_addr/I_data into O_ram_we/O_ram_addr/O_ram_wdata, set O_ram_en=1, O_ready=0, counter=WAIT_STATES; go to ACCESS.
  - ACCESS (one cycle): O_ram_en<=0, O_ram_we<=0 (RAM samples at E1); go to WAIT.
  - WAIT: if counter!=0, decrement and stay. If counter==0:
    - Read: O_data<=I_ram_rdata, O_data_ready<=1.
    - Both read and write: O_ready<=1; go to IDLE.
- Latency: request sampled at E0, completion visible after edge E(2+WAIT_STATES) for reads and writes alike.
- O_data_ready is high for exactly one cycle, and in the same cycle O_ready is already 1.
- O_ram_addr and O_ram_wdata change only when a request is accepted; they hold from acceptance through completion.
- Request while busy (req with O_ready=0, including the completion edge itself): ignored, O_overrun<=1.
  - The in-flight access is unaffected; O_overrun clears only on reset.
- Request in the first IDLE cycle after completion is accepted normally (back-to-back accesses, no gap cycle required).
- WAIT_STATES values above 15 are illegal; no checking is done.

Test Plan:
- Reset then idle: I_reset pulsed low mid-cycle, asynchronously -> all outputs at reset values immediately; O_ready=1 after release.
- Read, WAIT_STATES=0: I_execute 1 cycle, I_we=0, I_addr=0x0010, RAM returns 0xBEEF -> O_ram_en high exactly 1 cycle with O_ram_addr=0x0010; O_data_ready pulses 2 cycles after request with O_data=0xBEEF, O_ready=1 in that cycle.
- Write, WAIT_STATES=3: I_we=1, I_addr=0x0020, I_data=0x1234 -> O_ram_en=O_ram_we=1 for 1 cycle with addr/wdata stable; O_ready returns high 5 cycles after request; O_data_ready never asserts; O_data unchanged.
- Held and overlapping requests: I_execute held high 4 cycles -> exactly one access, O_overrun=0. A second rising edge during WAIT -> O_overrun=1 and stays 1; the first access completes normally.
- Back-to-back, control-unit style: fetch read, then READ at the next O_ready -> two separate O_data_ready pulses with the correct data; no dropped request.
- Reset mid-access: assert reset during WAIT -> O_ram_en=0, O_ready=1, no O_data_ready pulse; a new read after release completes normally.
